// File: rtl/rtype_mc_datapath.sv
// rtype_mc_datapath
// Multi-cycle RV64-style R-type datapath: register file, decoder, ALU and
// registered writeback, sequenced IDLE -> DECODE -> EXEC -> WB.
//
// Ports
//   clk, rst          clock / synchronous active-high reset
//   instr_valid/ready instruction handshake (ready only in IDLE)
//   instr             32-bit R-type encoding
//   ld_en/addr/data   register preload port, honoured in IDLE only
//   done              one-cycle retire pulse
//   illegal/overflow  retire status, valid with done and held until next done
//   wb_rd/wb_data     retire destination and result, held until next done
//   dbg_addr/data     combinational register-file peek (x0 reads 0)
//
// state  | meaning
// IDLE   | ready for an instruction; preload port active
// DECODE | operands read from RF, op and illegal flag decoded
// EXEC   | ALU result and overflow captured
// WB     | RF write (unless illegal or x0), retire outputs loaded
module rtype_mc_datapath #(
   parameter int XLEN = 64,
   parameter int NREGS = 32,
   localparam int AW = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   input  logic            ld_en,
   input  logic [AW-1:0]   ld_addr,
   input  logic [XLEN-1:0] ld_data,
   output logic            done,
   output logic            illegal,
   output logic            overflow,
   output logic [AW-1:0]   wb_rd,
   output logic [XLEN-1:0] wb_data,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_WB     = 2'd3;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SLT  = 3'd5;
   localparam logic [2:0] OP_SLTU = 3'd6;

   logic [1:0]      state_q, state_d;
   logic [31:0]     ir_q;
   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] a_q, b_q, r_q;
   logic [2:0]      op_q, op_d;
   logic            illegal_q, illegal_d;
   logic            ovf_q, ovf_d;
   logic [XLEN-1:0] alu_res;

   logic            done_q, illegal_out_q, overflow_out_q;
   logic [AW-1:0]   wb_rd_q;
   logic [XLEN-1:0] wb_data_q;

   logic [AW-1:0]   rs1, rs2, rd;
   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;

   // Index bits above AW are dropped so a small register file aliases.
   assign rs1    = ir_q[15 +: AW];
   assign rs2    = ir_q[20 +: AW];
   assign rd     = ir_q[7 +: AW];
   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign funct7 = ir_q[31:25];

   assign instr_ready = (state_q == ST_IDLE);
   assign dbg_data    = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

   assign done     = done_q;
   assign illegal  = illegal_out_q;
   assign overflow = overflow_out_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = ST_WB;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      op_d      = OP_ADD;
      illegal_d = 1'b1;
      if (opcode == 7'b0110011) begin
         unique case ({funct7, funct3})
            10'b0000000_000: begin op_d = OP_ADD;  illegal_d = 1'b0; end
            10'b0100000_000: begin op_d = OP_SUB;  illegal_d = 1'b0; end
            10'b0000000_111: begin op_d = OP_AND;  illegal_d = 1'b0; end
            10'b0000000_110: begin op_d = OP_OR;   illegal_d = 1'b0; end
            10'b0000000_100: begin op_d = OP_XOR;  illegal_d = 1'b0; end
            10'b0000000_010: begin op_d = OP_SLT;  illegal_d = 1'b0; end
            10'b0000000_011: begin op_d = OP_SLTU; illegal_d = 1'b0; end
            default: ;
         endcase
      end
   end

   always_comb begin
      alu_res = '0;
      ovf_d   = 1'b0;
      unique case (op_q)
         OP_ADD: begin
            alu_res = a_q + b_q;
            ovf_d   = (a_q[XLEN-1] == b_q[XLEN-1]) && (alu_res[XLEN-1] != a_q[XLEN-1]);
         end
         OP_SUB: begin
            alu_res = a_q - b_q;
            ovf_d   = (a_q[XLEN-1] != b_q[XLEN-1]) && (alu_res[XLEN-1] != a_q[XLEN-1]);
         end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         ir_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         r_q            <= '0;
         op_q           <= OP_ADD;
         illegal_q      <= 1'b0;
         ovf_q          <= 1'b0;
         done_q         <= 1'b0;
         illegal_out_q  <= 1'b0;
         overflow_out_q <= 1'b0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (ld_en && (ld_addr != '0)) rf_q[ld_addr] <= ld_data;
               if (instr_valid) ir_q <= instr;
            end
            ST_DECODE: begin
               a_q       <= (rs1 == '0) ? '0 : rf_q[rs1];
               b_q       <= (rs2 == '0) ? '0 : rf_q[rs2];
               op_q      <= op_d;
               illegal_q <= illegal_d;
            end
            ST_EXEC: begin
               r_q   <= alu_res;
               ovf_q <= ovf_d;
            end
            default: begin
               if (!illegal_q && (rd != '0)) rf_q[rd] <= r_q;
               done_q         <= 1'b1;
               wb_rd_q        <= rd;
               wb_data_q      <= illegal_q ? '0 : r_q;
               illegal_out_q  <= illegal_q;
               overflow_out_q <= ovf_q & ~illegal_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rtype_mc_datapath.sv
module tb_rtype_mc_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        ld_en;
   logic [4:0]  ld_addr;
   logic [63:0] ld_data;
   logic        done;
   logic        illegal;
   logic        overflow;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic [4:0]  dbg_addr;
   logic [63:0] dbg_data;

   rtype_mc_datapath dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .done(done), .illegal(illegal), .overflow(overflow),
      .wb_rd(wb_rd), .wb_data(wb_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic        ill;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] mrf [32];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   // Reference: 65-bit sign-extended arithmetic for overflow, program-order RF update.
   function automatic void model_exec(input logic [31:0] ins, output exp_t e);
      logic [63:0] a, b, r;
      logic [64:0] s;
      logic        ill, ovf;
      a   = mrf[ins[19:15]];
      b   = mrf[ins[24:20]];
      r   = '0;
      ovf = 1'b0;
      ill = 1'b0;
      if (ins[6:0] != 7'b0110011) ill = 1'b1;
      else begin
         case ({ins[31:25], ins[14:12]})
            10'b0000000_000: begin s = {a[63], a} + {b[63], b}; r = s[63:0]; ovf = s[64] ^ s[63]; end
            10'b0100000_000: begin s = {a[63], a} - {b[63], b}; r = s[63:0]; ovf = s[64] ^ s[63]; end
            10'b0000000_111: r = a & b;
            10'b0000000_110: r = a | b;
            10'b0000000_100: r = a ^ b;
            10'b0000000_010: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            10'b0000000_011: r = (a < b) ? 64'd1 : 64'd0;
            default: ill = 1'b1;
         endcase
      end
      if (!ill && ins[11:7] != 5'd0) mrf[ins[11:7]] = r;
      e.rd   = ins[11:7];
      e.data = ill ? 64'd0 : r;
      e.ill  = ill;
      e.ovf  = ill ? 1'b0 : ovf;
      e.cyc  = 0;
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
            chk("wb_data", wb_data, e.data);
            chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
            chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
            chk("latency", 64'(cyc - e.cyc), 64'd4);
         end
      end
   end

   task automatic load(input logic [4:0] a, input logic [63:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      if (a != 5'd0) mrf[a] = d;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Leaves instr_valid high on return so a following call is back-to-back.
   task automatic issue(input logic [31:0] ins, input bit do_ld = 1'b0,
                        input logic [4:0] la = 5'd0, input logic [63:0] ldv = 64'd0);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      @(negedge clk);
      instr = ins;
      instr_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (instr_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         chk("accept_timeout", 64'd0, 64'd1);
         instr_valid = 1'b0;
         return;
      end
      if (do_ld) begin
         ld_en = 1'b1; ld_addr = la; ld_data = ldv;
         if (la != 5'd0) mrf[la] = ldv;
      end
      model_exec(ins, e);
      e.cyc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic drain();
      @(negedge clk);
      instr_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #2;
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_dbg(input logic [4:0] a);
      dbg_addr = a;
      #1;
      chk($sformatf("dbg_x%0d", a), dbg_data, mrf[a]);
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {63'd0, instr_ready}, 64'd1);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
      chk_dbg(5'd5);

      load(5'd5, 64'd5);
      load(5'd6, 64'd6);
      issue(32'h006283B3);
      drain();
      chk_dbg(5'd7);
      chk("add_x7_value", mrf[7], 64'd11);

      load(5'd1, 64'h7FFF_FFFF_FFFF_FFFF);
      load(5'd2, 64'd1);
      issue(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3));
      drain();
      load(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3));
      drain();
      chk_dbg(5'd3);

      issue(rtype(7'b0000000, 5'd5, 5'd1, 3'b010, 5'd8));
      issue(rtype(7'b0000000, 5'd5, 5'd1, 3'b011, 5'd8));
      issue(rtype(7'b0000000, 5'd5, 5'd1, 3'b100, 5'd9));
      issue(rtype(7'b0000000, 5'd5, 5'd1, 3'b111, 5'd10));
      issue(rtype(7'b0000000, 5'd5, 5'd1, 3'b110, 5'd11));
      drain();
      chk_dbg(5'd9);

      issue(rtype(7'b0000000, 5'd6, 5'd5, 3'b000, 5'd0));
      drain();
      chk_dbg(5'd0);
      issue(rtype(7'b0100000, 5'd5, 5'd1, 3'b111, 5'd9));
      issue({rtype(7'b0000000, 5'd5, 5'd1, 3'b000, 5'd9)} ^ 32'h0000_0020);
      drain();
      chk_dbg(5'd9);

      // Back-to-back: second reads the first's destination.
      issue(rtype(7'b0000000, 5'd6, 5'd5, 3'b000, 5'd12));
      issue(rtype(7'b0000000, 5'd12, 5'd12, 3'b000, 5'd13));
      drain();
      chk_dbg(5'd13);

      // Load strobe during EXEC must be ignored.
      issue(rtype(7'b0000000, 5'd5, 5'd5, 3'b000, 5'd14));
      @(negedge clk) instr_valid = 1'b0;
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 5'd15; ld_data = 64'hDEAD;
      @(posedge clk);
      #1 ld_en = 1'b0;
      drain();
      chk_dbg(5'd15);

      // Load and accept in the same IDLE cycle.
      issue(rtype(7'b0000000, 5'd5, 5'd16, 3'b000, 5'd17), 1'b1, 5'd16, 64'd100);
      drain();
      chk_dbg(5'd17);

      // Reset during EXEC aborts the instruction.
      issue(32'h006283B3);
      @(negedge clk) instr_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      @(negedge clk) rst = 1'b0;
      chk("abort_ready", {63'd0, instr_ready}, 64'd1);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_wb_data", wb_data, 64'd0);
      chk("abort_wb_rd", {59'd0, wb_rd}, 64'd0);
      chk("abort_flags", {62'd0, illegal, overflow}, 64'd0);
      repeat (6) @(negedge clk);
      chk_dbg(5'd7);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rtype_mc_datapath.md
Name: rtype_mc_datapath

Overview:
- Parametrised, multi-cycle RV64-style R-type datapath: register file, decoder, ALU and writeback, sequenced by an FSM with a valid/ready instruction handshake.
- Generalises the single-cycle R-type datapath:
  - adds XLEN and register-count parameters, an x0 hardwired to zero, and illegal-instruction detection;
  - adds XOR/SLTU and a register load port replacing hardcoded preloads;
  - registers writeback on clk only.
- Sits between an instruction source (testbench or fetch unit) and downstream result consumers.

Parameters:
- XLEN, 64, datapath/register width in bits (legal 8..64).
- NREGS, 32, number of architectural registers (power of 2, ≤32); AW = clog2(NREGS).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept; high only in IDLE.
- instr  in  32  RISC-V R-type encoding.
- ld_en  in  1  register load strobe (test/boot).
- ld_addr  in  AW  load target register.
- ld_data  in  XLEN  load value.
- done  out  1  one-cycle pulse: instruction retired.
- illegal  out  1  valid with done: instruction rejected, no write.
- overflow  out  1  valid with done: signed overflow on ADD/SUB.
- wb_rd  out  AW  valid with done: destination index.
- wb_data  out  XLEN  valid with done: ALU result (0 when illegal).
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  combinational RF[dbg_addr]; 0 when dbg_addr==0.

Behaviour:
- Reset: state=IDLE, all registers 0, operand/result regs 0, done=illegal=overflow=0, wb_rd=0, wb_data=0, instr_ready=1 the cycle after reset deasserts. Reset mid-instruction aborts it; no RF write, no done.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. On instr_valid, latch instr into IR and go to DECODE. Otherwise stay.
  - DECODE: A <= RF[rs1], B <= RF[rs2] (index 0 reads 0). Register index bits above AW are ignored. Set illegal_q per the decode table below. Go to EXEC.
  - EXEC: R <= ALU(A,B). ovf_q <= signed overflow for ADD (sign(A)==sign(B)!=sign(R)) and SUB (sign(A)!=sign(B), sign(R)!=sign(A)); 0 for other ops. Go to WB.
  - WB: if !illegal_q and rd!=0, RF[rd] <= R. Registered outputs update at the WB edge and show in the following (IDLE) cycle: done=1 for that one cycle; wb_data=R (0 if illegal); overflow=ovf_q&!illegal_q; illegal=illegal_q; wb_rd=rd. Go to IDLE.
- Latency: accept edge T → done high in cycle T+4 (after the WB edge); throughput 1 instruction per 4 cycles. The next instruction may be accepted in the same cycle done is high. wb_rd/wb_data/illegal/overflow hold until the next done.
- Decode table: opcode must be 0110011; funct7/funct3 combinations:
  - 0000000/000 ADD
  - 0100000/000 SUB
  - 0000000/111 AND
  - 0000000/110 OR
  - 0000000/100 XOR
  - 0000000/010 SLT (signed)
  - 0000000/011 SLTU
  - anything else → illegal.
- Arithmetic: all ops modulo 2^XLEN. SLT/SLTU return 0 or 1 zero-extended. Writes to x0 are discarded; done still pulses with wb_rd=0 and the real wb_data.
- Load port: honoured only in IDLE; ignored in any other state. ld_addr==0 is ignored. If ld_en and an accept occur in the same IDLE cycle, both happen; the instruction's DECODE reads the loaded value.
- Debug read of the register being written in WB returns the old value that cycle, the new value thereafter.

Test Plan:
- Reset, then ld x5=5, x6=6; ADD x7,x5,x6 (0x006283B3) → done 4 cycles after accept, wb_rd=7, wb_data=11, overflow=0, dbg x7=11.
- ld x1=0x7FFF_FFFF_FFFF_FFFF, x2=1; ADD x3,x1,x2 → wb_data=0x8000_0000_0000_0000, overflow=1. Then ld x1=0xFFFF_FFFF_FFFF_FFFF, x2=1; SUB x3,x1,x2 → 0xFFFF_FFFF_FFFF_FFFE, overflow=0.
- x1=0xFFFF_FFFF_FFFF_FFFF, x5=5: SLT x8,x1,x5 → 1; SLTU x8,x1,x5 → 0; XOR x9,x1,x5 → 0xFFFF_FFFF_FFFF_FFFA; AND → 5; OR → all ones.
- ADD x0,x5,x6 → done, wb_rd=0, wb_data=11, dbg x0=0. funct7=0100000 with funct3=111 → illegal=1, wb_data=0, destination unchanged.
- Back-to-back: hold instr_valid high with 2 instructions (second reads first's rd) → second accepted in first's done cycle and sees the updated value. ld_en asserted during EXEC → ignored.
- rst asserted during EXEC of ADD x7 → no done, x7 keeps 0, instr_ready=1 after reset, all outputs 0.
